// File: rtl/onehot_decoder_buf.sv
// Binary index to one-hot decoder with a 2-entry output buffer and valid/ready on both sides.
// Outputs come from registered state only; there is no combinational path from input to output.
module onehot_decoder_buf #(
   parameter int IN_W  = 3,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8,
   localparam int OUT_W = 1 << IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_index,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_onehot,
   output logic [CNT_W-1:0] dec_count
);

   logic [OUT_W-1:0] mem_q [DEPTH];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q, count_d;
   logic [CNT_W-1:0] dec_count_q, dec_count_d;
   logic             push, pop;

   assign in_ready   = (count_q != 2'(DEPTH));
   assign out_valid  = (count_q != 2'd0);
   assign out_onehot = out_valid ? mem_q[rd_ptr_q] : '0;
   assign dec_count  = dec_count_q;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      count_d     = count_q;
      dec_count_d = dec_count_q;
      if (push) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d    = ~rd_ptr_q;
         dec_count_d = dec_count_q + CNT_W'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      if (push && !pop) begin
         count_d = count_q + 2'd1;
      end else if (pop && !push) begin
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         dec_count_q <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         dec_count_q <= dec_count_d;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            mem_q[gi] <= '0;
         end else if (push && (wr_ptr_q == 1'(gi))) begin
            mem_q[gi] <= OUT_W'(1) << in_index;
         end
      end
   end

endmodule
